// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction field layout, FSM states.
// No logic; latency n/a.
// Backpressure n/a.
package alu_pkg;

    localparam int INSTR_W  = 16;
    localparam int DATA_W   = 8;
    localparam int REG_AW   = 3;
    localparam int OP_LSB   = 13;
    localparam int RD_LSB   = 10;
    localparam int RA_LSB   = 7;
    localparam int RB_LSB   = 4;
    localparam int OFF_LO_W = 4;
    localparam int OFF_W    = 7;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_NOT = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_ASR = 3'd4,
        OP_SHL = 3'd5,
        OP_BEQ = 3'd6,
        OP_BNE = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    function automatic logic is_branch(input logic [2:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    // Branch offset is split: high bits share the rd field, low bits sit at the bottom.
    function automatic logic [OFF_W-1:0] branch_off(input logic [INSTR_W-1:0] ins);
        return {ins[RD_LSB +: REG_AW], ins[OFF_LO_W-1:0]};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake channel from fetch into the issue controller.
// Latency n/a (wires only).
// Backpressure: instr_ready low stalls the producer, which holds instr.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/regfile_8x8.sv
// 8x8 register file, r0 reads zero, two operand read ports + debug read, one write port.
// Reads combinational; write visible the cycle after it is issued.
// No backpressure.
module regfile_8x8
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [8];

    // Entry 0 is reset and never written, so it always reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external combinational ALU, writes back and advances pc.
// Latency: accept at T, retire pulse at T+2, next accept at T+3.
// Backpressure: instr_ready only in IDLE; valid outside IDLE is ignored.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   ifc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_s,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_ovf,
    input  logic              alu_take_branch,
    output logic [PC_W-1:0]   pc,
    output logic              retire_valid,
    output logic              retire_taken,
    output logic              ovf_sticky,
    input  logic              ovf_clr,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state;
    logic [REG_AW-1:0] rd_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] f_cap;
    logic              ovf_cap;
    logic              taken_cap;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              handshake;
    logic              wb_we;
    logic              ovf_set;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_br;

    assign ifc.instr_ready = (state == IDLE);
    assign handshake       = ifc.instr_valid & ifc.instr_ready;
    assign wb_we           = (state == WB) && !is_branch(alu_s);
    assign ovf_set         = (state == WB) && (alu_s == OP_ADD) && ovf_cap;
    assign pc_inc          = pc + PC_W'(1);
    assign pc_br           = pc_inc + PC_W'($signed(off_q));

    // Operands are read straight from the incoming instruction so they can be registered on accept.
    regfile_8x8 u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (ifc.instr[RA_LSB +: REG_AW]),
        .rb_addr  (ifc.instr[RB_LSB +: REG_AW]),
        .dbg_addr (dbg_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .dbg_data (dbg_data),
        .we       (wb_we),
        .waddr    (rd_q),
        .wdata    (f_cap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            rd_q         <= '0;
            off_q        <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_s        <= '0;
            f_cap        <= '0;
            ovf_cap      <= 1'b0;
            taken_cap    <= 1'b0;
            retire_valid <= 1'b0;
            retire_taken <= 1'b0;
            ovf_sticky   <= 1'b0;
        end else begin
            retire_valid <= 1'b0;
            retire_taken <= 1'b0;
            // A new overflow beats a simultaneous clear.
            if (ovf_set) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (handshake) begin
                        rd_q  <= ifc.instr[RD_LSB +: REG_AW];
                        off_q <= branch_off(ifc.instr);
                        alu_a <= ra_data;
                        alu_b <= rb_data;
                        alu_s <= ifc.instr[OP_LSB +: 3];
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    f_cap        <= alu_f;
                    ovf_cap      <= alu_ovf;
                    taken_cap    <= alu_take_branch;
                    retire_valid <= 1'b1;
                    retire_taken <= is_branch(alu_s) & alu_take_branch;
                    state        <= WB;
                end
                WB: begin
                    pc    <= (is_branch(alu_s) && taken_cap) ? pc_br : pc_inc;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed + random bench for alu_issue_ctrl with a behavioural ALU and an arithmetic reference model.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_a, alu_b, alu_f;
    logic [2:0] alu_s;
    logic       alu_ovf, alu_take_branch;
    logic [7:0] pc;
    logic       retire_valid, retire_taken, ovf_sticky, ovf_clr;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;
    logic [7:0] alu_sum;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] R [8];
    int         pc_m;
    bit         sticky_m;
    logic       obs_taken;

    always #10 clk = ~clk;

    alu_issue_ctrl_if ifc ();

    alu_issue_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk             (clk),
        .rst             (rst),
        .ifc             (ifc),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_s           (alu_s),
        .alu_f           (alu_f),
        .alu_ovf         (alu_ovf),
        .alu_take_branch (alu_take_branch),
        .pc              (pc),
        .retire_valid    (retire_valid),
        .retire_taken    (retire_taken),
        .ovf_sticky      (ovf_sticky),
        .ovf_clr         (ovf_clr),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    // Combinational 8-bit ALU the controller drives.
    assign alu_sum = alu_a + alu_b;
    assign alu_ovf = (alu_a[7] == alu_b[7]) && (alu_sum[7] != alu_a[7]);
    always_comb begin
        alu_f           = 8'h00;
        alu_take_branch = 1'b0;
        case (alu_s)
            3'd0: alu_f = alu_sum;
            3'd1: alu_f = ~alu_b;
            3'd2: alu_f = alu_a & alu_b;
            3'd3: alu_f = alu_a | alu_b;
            3'd4: alu_f = {alu_a[7], alu_a[7:1]};
            3'd5: alu_f = {alu_a[6:0], 1'b0};
            3'd6: alu_take_branch = (alu_a == alu_b);
            default: alu_take_branch = (alu_a != alu_b);
        endcase
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_dbg(input int a, output logic [7:0] v);
        dbg_addr = a[2:0];
        #1;
        v = dbg_data;
    endtask

    function automatic logic [15:0] mk(input int op, input int rd, input int ra, input int rb, input int lo);
        return {op[2:0], rd[2:0], ra[2:0], rb[2:0], lo[3:0]};
    endfunction

    function automatic logic [15:0] mkb(input int op, input int ra, input int rb, input int off);
        logic [6:0] f;
        f = off[6:0];
        return {op[2:0], f[6:4], ra[2:0], rb[2:0], f[3:0]};
    endfunction

    // Issue one instruction and check every stage against the model. Entered at posedge+1 in IDLE.
    task automatic issue(input logic [15:0] ins, input bit clr);
        int op, rd, ra, rb, off, sa, sb, res, n;
        bit ovf, tk;
        logic [7:0] a, b, old_rd, v;
        n = 0;
        while (ifc.instr_ready !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_bound", (n < 8), 1);
        op = ins[15:13]; rd = ins[12:10]; ra = ins[9:7]; rb = ins[6:4];
        off = {ins[12:10], ins[3:0]};
        if (off >= 64) off -= 128;
        a = R[ra]; b = R[rb];
        sa = $signed(a); sb = $signed(b);
        ovf = 0; tk = 0; res = 0;
        case (op)
            0: begin res = sa + sb; ovf = (res > 127) || (res < -128); end
            1: res = 255 - b;
            2: res = a & b;
            3: res = a | b;
            4: res = (sa < 0) ? (sa - 1) / 2 : sa / 2;
            5: res = a * 2;
            6: tk = (a == b);
            default: tk = (a != b);
        endcase
        old_rd = R[rd];
        ifc.instr = ins; ifc.instr_valid = 1'b1; ovf_clr = clr;
        @(posedge clk); #1;
        ifc.instr_valid = 1'b0;
        ifc.instr = 16'($urandom);
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        chk("exec_alu_s", alu_s, op);
        chk("exec_ready", ifc.instr_ready, 0);
        chk("exec_retire", retire_valid, 0);
        @(posedge clk); #1;
        chk("wb_retire", retire_valid, 1);
        chk("wb_taken", retire_taken, tk);
        obs_taken = retire_taken;
        if (op < 6) begin
            rd_dbg(rd, v);
            chk("wb_dbg_old", v, old_rd);
        end
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        if (op < 6 && rd != 0) R[rd] = res[7:0];
        if (clr) sticky_m = 0;
        if (op == 0 && ovf) sticky_m = 1;
        pc_m = ((pc_m + 1 + (tk ? off : 0)) % 256 + 256) % 256;
        chk("idle_retire", retire_valid, 0);
        chk("idle_ready", ifc.instr_ready, 1);
        chk("idle_pc", pc, pc_m);
        chk("idle_sticky", ovf_sticky, sticky_m);
        rd_dbg(rd, v);
        chk("idle_dbg_rd", v, R[rd]);
    endtask

    task automatic load(input int rd, input logic [7:0] val);
        issue(mk(OP_AND, rd, 0, 0, 0), 0);
        for (int i = 7; i >= 0; i--) begin
            issue(mk(OP_SHL, rd, rd, 0, 0), 0);
            if (val[i]) issue(mk(OP_ADD, rd, rd, 7, 0), 0);
        end
    endtask

    task automatic goto_pc(input int target);
        int d, g;
        g = 0;
        while (pc_m != target && g < 8) begin
            d = ((target - pc_m - 1) % 256 + 256) % 256;
            if (d >= 128) d -= 256;
            if (d > 63) d = 63;
            if (d < -64) d = -64;
            issue(mkb(OP_BEQ, 0, 0, d), 0);
            g++;
        end
        chk("goto_pc", pc, target);
    endtask

    task automatic reset_checks();
        logic [7:0] v;
        chk("rst_pc", pc, 0);
        chk("rst_ready", ifc.instr_ready, 1);
        chk("rst_alu_s", alu_s, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_sticky", ovf_sticky, 0);
        chk("rst_retire", retire_valid, 0);
        for (int i = 0; i < 8; i++) begin
            rd_dbg(i, v);
            chk("rst_dbg", v, 0);
        end
    endtask

    initial begin
        logic [7:0] v;
        int hs, old_pc;
        rst = 1'b1; ifc.instr_valid = 1'b0; ifc.instr = '0; ovf_clr = 1'b0; dbg_addr = '0;
        for (int i = 0; i < 8; i++) R[i] = 8'h00;
        pc_m = 0; sticky_m = 0; obs_taken = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        @(posedge clk); #1;
        rst = 1'b0;

        // r7 = 1 is the increment used to build constants.
        issue(mk(OP_NOT, 7, 0, 0, 0), 0);
        issue(mk(OP_SHL, 7, 7, 0, 0), 0);
        issue(mk(OP_NOT, 7, 0, 7, 0), 0);

        // ADD overflow, clear, then set-wins-over-clear
        load(1, 8'h7F);
        load(2, 8'h01);
        issue(mk(OP_ADD, 3, 1, 2, 0), 0);
        rd_dbg(3, v);
        chk("ovf_r3", v, 8'h80);
        chk("ovf_sticky_set", ovf_sticky, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        sticky_m = 0;
        chk("ovf_sticky_clr", ovf_sticky, 0);
        issue(mk(OP_ADD, 3, 1, 2, 0), 1);
        chk("ovf_set_wins", ovf_sticky, 1);
        issue(mk(OP_OR, 4, 1, 2, 0), 1);
        chk("ovf_clr_no_add", ovf_sticky, 0);

        // write to r0 is dropped
        load(1, 8'h05);
        load(2, 8'h03);
        old_pc = pc_m;
        issue(mk(OP_ADD, 0, 1, 2, 0), 0);
        rd_dbg(0, v);
        chk("r0_write", v, 8'h00);
        chk("r0_pc_inc", pc, (old_pc + 1) % 256);

        // branches
        load(1, 8'h10);
        load(2, 8'h10);
        goto_pc(8'h20);
        issue(mkb(OP_BEQ, 1, 2, 5), 0);
        chk("beq_pc", pc, 8'h26);
        chk("beq_taken", obs_taken, 1);
        issue(mkb(OP_BNE, 1, 2, 5), 0);
        chk("bne_pc", pc, 8'h27);
        chk("bne_taken", obs_taken, 0);

        // backward branch wrapping below zero, then increment wrapping past 0xFF
        goto_pc(8'h02);
        issue(mkb(OP_BEQ, 0, 0, -4), 0);
        chk("wrap_back_pc", pc, 8'hFF);
        issue(mk(OP_OR, 5, 1, 2, 0), 0);
        chk("wrap_fwd_pc", pc, 8'h00);

        // valid held high for 9 cycles
        issue(mk(OP_AND, 4, 0, 0, 0), 0);
        hs = 0;
        ifc.instr = mk(OP_ADD, 4, 4, 7, 0);
        ifc.instr_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk("b2b_ready", ifc.instr_ready, (k % 3 == 0));
            if (ifc.instr_valid && ifc.instr_ready) hs++;
            @(posedge clk); #1;
        end
        ifc.instr_valid = 1'b0;
        chk("b2b_handshakes", hs, 3);
        R[4] = R[4] + 3 * R[7];
        pc_m = (pc_m + 3) % 256;
        rd_dbg(4, v);
        chk("b2b_r4", v, R[4]);
        chk("b2b_pc", pc, pc_m);

        // random instructions against the model
        for (int i = 0; i < 40; i++) begin
            issue(mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        // reset during EXEC abandons the instruction
        ifc.instr = mk(OP_NOT, 5, 0, 0, 0);
        ifc.instr_valid = 1'b1;
        @(posedge clk); #1;
        ifc.instr_valid = 1'b0;
        chk("mid_rst_in_exec", ifc.instr_ready, 0);
        rst = 1'b1;
        #2;
        chk("mid_rst_async_pc", pc, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) R[i] = 8'h00;
        pc_m = 0; sticky_m = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_retire", retire_valid, 0);
        end
        reset_checks();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
